// File: rtl/rca_accumulator_pkg.sv
// Shared constants for the rca_accumulator slice: default operand/sum width
// (must match the ripple-carry adder) and default term-count field width.
// No ports; imported by rca_accumulator and rca_accumulator_rca.
package rca_accumulator_pkg;

  // Operand and sum width shared with the ripple-carry adder.
  localparam int NBIT_DEF    = 8;
  // Term-count field width; a job carries at most 2^NTERM_W-1 operands.
  localparam int NTERM_W_DEF = 4;

endpackage

// File: rtl/rca_accumulator_rca.sv
// Decomposed ripple-carry adder: NBIT chained full adders, purely combinational.
// Ports: i_a, i_b (NBIT operands) -> o_s (NBIT sum, modulo 2^NBIT).
// Critical path is NBIT full-adder delays; no pipelining.
module rca_accumulator_rca
  import rca_accumulator_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) (
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  output logic [NBIT-1:0] o_s
);

  // w_c[i] is the carry into bit i; the final carry-out is not needed here
  // because the caller detects wrap from the sum itself.
  logic [NBIT-1:0] w_c;

  assign w_c[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NBIT; gi++) begin : g_fa
      assign o_s[gi] = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      if (gi < NBIT - 1) begin : g_carry
        assign w_c[gi+1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/rca_accumulator.sv
// Job-based accumulator: sums a counted stream of NBIT-bit operands through the
// ripple-carry adder and presents the total with a sticky wrap flag.
// Ports: i_clk/i_rst (sync, active-high); i_start/i_nterms job request;
//   i_in_valid/i_in_data/o_in_ready operand stream; o_out_valid/o_out_sum/
//   o_out_ovf/i_out_ready result; o_busy = not idle.
// Latency: result valid the cycle after the last accepted operand (one cycle
//   after start for an empty job). Result is held until i_out_ready.
// Build option: define ACC_SAT_EN to saturate at all-ones on the first wrap
//   instead of wrapping modulo 2^NBIT; ports are identical in both builds.
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int NBIT    = NBIT_DEF,
  parameter int NTERM_W = NTERM_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NTERM_W-1:0] i_nterms,
  input  logic               i_in_valid,
  input  logic [NBIT-1:0]    i_in_data,
  output logic               o_in_ready,
  output logic               o_out_valid,
  output logic [NBIT-1:0]    o_out_sum,
  output logic               o_out_ovf,
  input  logic               i_out_ready,
  output logic               o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NBIT-1:0]     r_acc;
  logic                r_ovf;
  logic [NTERM_W-1:0]  r_cnt;
  logic [NBIT-1:0]     r_out_sum;
  logic                r_out_ovf;

  logic [NBIT-1:0]     w_sum;
  logic [NBIT-1:0]     w_acc_nxt;
  logic                w_wrap;
  logic                w_ovf_nxt;
  logic                w_xfer;

  rca_accumulator_rca #(
    .NBIT (NBIT)
  ) u_rca (
    .i_a (r_acc),
    .i_b (i_in_data),
    .o_s (w_sum)
  );

  // An unsigned modulo add wrapped exactly when the result is below the
  // original accumulator value.
  assign w_wrap    = (w_sum < r_acc);
  assign w_ovf_nxt = r_ovf | w_wrap;
  assign w_xfer    = (r_state == ACCUM) && i_in_valid;

`ifdef ACC_SAT_EN
  // Once pinned at all-ones every further add wraps again (or adds zero), so
  // the accumulator stays saturated for the rest of the job.
  assign w_acc_nxt = w_wrap ? {NBIT{1'b1}} : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = (i_nterms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        o_in_ready = 1'b1;
        if (w_xfer && (r_cnt == NTERM_W'(1))) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. The result registers are loaded only on entry to DONE so the
  // outputs keep the last job's value while a new job accumulates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_out_sum <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= i_nterms;
            if (i_nterms == '0) begin
              r_out_sum <= '0;
              r_out_ovf <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == NTERM_W'(1)) begin
              r_out_sum <= w_acc_nxt;
              r_out_ovf <= w_ovf_nxt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_out_sum = r_out_sum;
  assign o_out_ovf = r_out_ovf;

endmodule

// File: tb/tb_rca_accumulator.sv
module tb_rca_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] nterms;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       out_ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: job phase (0 idle, 1 collecting, 2 result), operands
  // still owed, and the exact (unbounded) integer total of the job.
  int m_phase = 0;
  int m_left  = 0;
  int m_total = 0;

  logic [7:0] jd [16];

  rca_accumulator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_nterms    (nterms),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_sum   (out_sum),
    .o_out_ovf   (out_ovf),
    .i_out_ready (out_ready),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Wrapping accumulation wraps at least once iff the exact total reaches 2^8;
  // saturation clamps at 255 from the first wrap onward.
  function automatic int exp_sum(input int t);
`ifdef ACC_SAT_EN
    return (t > 255) ? 255 : t;
`else
    return t % 256;
`endif
  endfunction

  function automatic int exp_ovf(input int t);
    return (t > 255) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_total <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total <= 0;
          if (nterms == 4'd0) m_phase <= 2;
          else begin
            m_left  <= int'(nterms);
            m_phase <= 1;
          end
        end
        1: if (in_valid) begin
          m_total <= m_total + int'(in_data);
          m_left  <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (m_phase == 1) ? 1 : 0);
      chk("out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("out_sum", int'(out_sum), exp_sum(m_total));
        chk("out_ovf", int'(out_ovf), exp_ovf(m_total));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job of n operands taken from jd, inserting random bubbles.
  task automatic feed(input int n, input int bubble_pct);
    int k;
    k = 0;
    start    = 1'b1;
    nterms   = 4'(n);
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400 && k < n; c++) begin
      if (int'($urandom_range(99)) < bubble_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = jd[k];
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  // Stall the result for hold cycles (optionally poking start and in_valid,
  // which must be ignored), then accept it.
  task automatic finish_job(input int hold, input int poke);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom);
      start     = 1'(poke);
      nterms    = 4'($urandom);
      tick();
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nterms = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // 1: 2+3+7 back to back.
    jd[0] = 8'd2; jd[1] = 8'd3; jd[2] = 8'd7;
    feed(3, 0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_sum", int'(out_sum), 12);
    chk("t1_ovf", int'(out_ovf), 0);
    finish_job(0, 0);
    chk("t1_busy", int'(busy), 0);

    // 2: 200+100 wraps (or saturates).
    jd[0] = 8'd200; jd[1] = 8'd100;
    feed(2, 0);
`ifdef ACC_SAT_EN
    chk("t2_sum", int'(out_sum), 255);
`else
    chk("t2_sum", int'(out_sum), 44);
`endif
    chk("t2_ovf", int'(out_ovf), 1);
    finish_job(0, 0);

    // 3: empty job.
    in_valid = 1'b1;
    in_data  = 8'd77;
    feed(0, 0);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_sum", int'(out_sum), 0);
    chk("t3_ovf", int'(out_ovf), 0);
    finish_job(2, 0);

    // 4: result held under back-pressure while start is pulsed.
    jd[0] = 8'd5; jd[1] = 8'd6;
    feed(2, 0);
    for (int h = 0; h < 5; h++) begin
      start = 1'b1; nterms = 4'd3; in_valid = 1'b1; in_data = 8'd9;
      tick();
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_sum", int'(out_sum), 11);
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_valid", int'(out_valid), 0);

    // 5: reset in the middle of a job, then a fresh job.
    start = 1'b1; nterms = 4'd4;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd9;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    chk("t5_in_ready", int'(in_ready), 0);
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_out_sum", int'(out_sum), 0);
    rst = 1'b0;
    tick();
    jd[0] = 8'd1; jd[1] = 8'd1;
    feed(2, 0);
    chk("t5_sum", int'(out_sum), 2);
    finish_job(0, 0);

    // 6: bubbles between transfers.
    begin
      bit         vp [6];
      logic [7:0] dp [6];
      vp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      dp = '{8'd4, 8'd99, 8'd99, 8'd5, 8'd77, 8'd6};
      start = 1'b1; nterms = 4'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
        in_valid = vp[i];
        in_data  = dp[i];
        tick();
      end
      in_valid = 1'b0;
      chk("t6_valid", int'(out_valid), 1);
      chk("t6_sum", int'(out_sum), 15);
      chk("t6_ovf", int'(out_ovf), 0);
      finish_job(1, 0);
    end

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      int n;
      n = int'($urandom_range(15));
      for (int i = 0; i < 16; i++) jd[i] = 8'($urandom);
      feed(n, 30);
      finish_job(int'($urandom_range(3)), int'($urandom_range(1)));
    end

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
